// File: rtl/sram_req_arbiter_if.sv
// Sram-like request/response bundle: one requester-side view (master) and
// one responder-side view (slave) of the same set of wires.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one downstream sram-like port between the CPU inst and data ports and
// routes in-order completions back through a FIFO of granted port ids.
module sram_req_arbiter #(
    parameter int MAX_OUT = 4,
    parameter bit RR_EN   = 1'b0
) (
    input  logic                aclk,
    input  logic                aresetn,
    sram_req_arbiter_if.slave   inst_if,
    sram_req_arbiter_if.slave   data_if,
    sram_req_arbiter_if.master  m_if,
    output logic                err_unexp
);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_e;

    logic [MAX_OUT-1:0] fifo_q, fifo_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               lock_q, lock_d;
    port_e              lock_id_q, lock_id_d;
    port_e              rr_last_q, rr_last_d;
    logic               err_q, err_d;

    port_e sel;
    port_e head;
    logic  full;
    logic  m_req;
    logic  accept;
    logic  pop;

    // A pending (not yet accepted) downstream request keeps its port via the lock.
    always_comb begin
        full = (cnt_q == FULL_CNT);
        sel  = PORT_INST;
        if (lock_q) begin
            sel = lock_id_q;
        end else if (RR_EN && inst_if.req && data_if.req) begin
            sel = (rr_last_q == PORT_DATA) ? PORT_INST : PORT_DATA;
        end else if (data_if.req) begin
            sel = PORT_DATA;
        end
        m_req  = aresetn & ~full & ((sel == PORT_DATA) ? data_if.req : inst_if.req);
        accept = m_req & m_if.addr_ok;
        pop    = aresetn & m_if.data_ok & (cnt_q != '0);
        head   = port_e'(fifo_q[rd_ptr_q]);
    end

    assign m_if.req   = m_req;
    assign m_if.wr    = (sel == PORT_DATA) ? data_if.wr    : inst_if.wr;
    assign m_if.size  = (sel == PORT_DATA) ? data_if.size  : inst_if.size;
    assign m_if.addr  = (sel == PORT_DATA) ? data_if.addr  : inst_if.addr;
    assign m_if.wdata = (sel == PORT_DATA) ? data_if.wdata : inst_if.wdata;

    assign inst_if.addr_ok = accept & (sel == PORT_INST);
    assign data_if.addr_ok = accept & (sel == PORT_DATA);
    assign inst_if.data_ok = pop & (head == PORT_INST);
    assign data_if.data_ok = pop & (head == PORT_DATA);
    assign inst_if.rdata   = m_if.rdata;
    assign data_if.rdata   = m_if.rdata;
    assign err_unexp       = err_q;

    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        rr_last_d = rr_last_q;
        err_d     = err_q | (m_if.data_ok & (cnt_q == '0));

        if (accept) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + PW'(1);
            lock_d           = 1'b0;
            if (RR_EN) begin
                rr_last_d = sel;
            end
        end else if (m_req) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            fifo_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= PORT_INST;
            rr_last_q <= PORT_INST;
            err_q     <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: a fixed-priority instance and a
// round-robin instance, driven cycle by cycle at the falling clock edge.
module tb_sram_req_arbiter;
    localparam logic [31:0] INST_ADDR = 32'h1000_0040;
    localparam logic [31:0] DATA_ADDR = 32'h2000_0080;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;

    logic aclk;
    logic aresetn;
    logic err0, err1;
    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t exp1_q[$];

    sram_req_arbiter_if inst0 ();
    sram_req_arbiter_if data0 ();
    sram_req_arbiter_if m0 ();
    sram_req_arbiter_if inst1 ();
    sram_req_arbiter_if data1 ();
    sram_req_arbiter_if m1 ();

    sram_req_arbiter #(.MAX_OUT(4), .RR_EN(1'b0)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .inst_if(inst0), .data_if(data0), .m_if(m0), .err_unexp(err0)
    );

    sram_req_arbiter #(.MAX_OUT(4), .RR_EN(1'b1)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .inst_if(inst1), .data_if(data1), .m_if(m1), .err_unexp(err1)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic idle_all();
        inst0.req = 0; inst0.wr = 0; inst0.size = 2'd2; inst0.addr = INST_ADDR; inst0.wdata = 32'h0;
        data0.req = 0; data0.wr = 1; data0.size = 2'd1; data0.addr = DATA_ADDR; data0.wdata = 32'h5555_AAAA;
        m0.addr_ok = 0; m0.data_ok = 0; m0.rdata = 32'h0;
        inst1.req = 0; inst1.wr = 0; inst1.size = 2'd2; inst1.addr = INST_ADDR; inst1.wdata = 32'h0;
        data1.req = 0; data1.wr = 1; data1.size = 2'd1; data1.addr = DATA_ADDR; data1.wdata = 32'h5555_AAAA;
        m1.addr_ok = 0; m1.data_ok = 0; m1.rdata = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        aresetn = 0;
        inst0.req = 1; data0.req = 1; m0.addr_ok = 1; m0.data_ok = 1;
        #1;
        total++;
        if (m0.req !== 1'b0 || inst0.addr_ok !== 1'b0 || data0.addr_ok !== 1'b0 ||
            inst0.data_ok !== 1'b0 || data0.data_ok !== 1'b0) begin
            bad++;
            $display("FAIL reset_forced: m_req=%b iaok=%b daok=%b idok=%b ddok=%b, required all 0",
                     m0.req, inst0.addr_ok, data0.addr_ok, inst0.data_ok, data0.data_ok);
        end
        @(negedge aclk);
        idle_all();
        aresetn = 1;
        #1;
        total++;
        if (err0 !== 1'b0 || err1 !== 1'b0 || m0.req !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: err0=%b err1=%b m_req=%b, required 0 0 0", err0, err1, m0.req);
        end
    endtask

    task automatic drain0(input string tag);
        exp_t e;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            @(negedge aclk);
            inst0.req = 0; data0.req = 0; m0.addr_ok = 0;
            m0.rdata = e.rdata; m0.data_ok = 1;
            #1;
            total++;
            if (data0.data_ok !== e.is_data || inst0.data_ok !== !e.is_data ||
                (e.is_data ? data0.rdata : inst0.rdata) !== e.rdata) begin
                bad++;
                $display("FAIL %s_return: ddok=%b idok=%b rdata=%h, required ddok=%b idok=%b rdata=%h",
                         tag, data0.data_ok, inst0.data_ok, e.is_data ? data0.rdata : inst0.rdata,
                         e.is_data, !e.is_data, e.rdata);
            end
        end
        @(negedge aclk);
        m0.data_ok = 0;
    endtask

    task automatic test_priority();
        @(negedge aclk);
        inst0.req = 1; data0.req = 1; m0.addr_ok = 1;
        #1;
        total++;
        if (data0.addr_ok !== 1'b1 || inst0.addr_ok !== 1'b0 || m0.addr !== DATA_ADDR || m0.wr !== 1'b1) begin
            bad++;
            $display("FAIL prio_data_first: daok=%b iaok=%b m_addr=%h m_wr=%b, required 1 0 %h 1",
                     data0.addr_ok, inst0.addr_ok, m0.addr, m0.wr, DATA_ADDR);
        end
        exp_q.push_back('{1'b1, 32'hAAAA_0001});
        @(negedge aclk);
        data0.req = 0;
        #1;
        total++;
        if (inst0.addr_ok !== 1'b1 || data0.addr_ok !== 1'b0 || m0.addr !== INST_ADDR) begin
            bad++;
            $display("FAIL prio_inst_second: iaok=%b daok=%b m_addr=%h, required 1 0 %h",
                     inst0.addr_ok, data0.addr_ok, m0.addr, INST_ADDR);
        end
        exp_q.push_back('{1'b0, 32'hBBBB_0002});
        drain0("prio");
    endtask

    task automatic test_lock();
        @(negedge aclk);
        inst0.req = 1; m0.addr_ok = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) data0.req = 1;
            #1;
            total++;
            if (m0.req !== 1'b1 || m0.addr !== INST_ADDR || inst0.addr_ok !== 1'b0 || data0.addr_ok !== 1'b0) begin
                bad++;
                $display("FAIL lock_hold_%0d: m_req=%b m_addr=%h iaok=%b daok=%b, required 1 %h 0 0",
                         c, m0.req, m0.addr, inst0.addr_ok, data0.addr_ok, INST_ADDR);
            end
            @(negedge aclk);
        end
        m0.addr_ok = 1;
        #1;
        total++;
        if (inst0.addr_ok !== 1'b1 || data0.addr_ok !== 1'b0 || m0.addr !== INST_ADDR) begin
            bad++;
            $display("FAIL lock_accept: iaok=%b daok=%b m_addr=%h, required 1 0 %h",
                     inst0.addr_ok, data0.addr_ok, m0.addr, INST_ADDR);
        end
        exp_q.push_back('{1'b0, 32'hC0DE_0001});
        @(negedge aclk);
        inst0.req = 0;
        #1;
        total++;
        if (data0.addr_ok !== 1'b1 || m0.addr !== DATA_ADDR) begin
            bad++;
            $display("FAIL lock_data_next: daok=%b m_addr=%h, required 1 %h", data0.addr_ok, m0.addr, DATA_ADDR);
        end
        exp_q.push_back('{1'b1, 32'hC0DE_0002});
        drain0("lock");
    endtask

    task automatic test_full();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            data0.req = 1; m0.addr_ok = 1;
            #1;
            total++;
            if (data0.addr_ok !== 1'b1) begin
                bad++;
                $display("FAIL full_fill_%0d: daok=%b, required 1", i, data0.addr_ok);
            end
            exp_q.push_back('{1'b1, 32'hD000_0000 + 32'(i)});
        end
        @(negedge aclk);
        #1;
        total++;
        if (m0.req !== 1'b0 || data0.addr_ok !== 1'b0) begin
            bad++;
            $display("FAIL full_block: m_req=%b daok=%b, required 0 0", m0.req, data0.addr_ok);
        end
        e = exp_q.pop_front();
        @(negedge aclk);
        m0.rdata = e.rdata; m0.data_ok = 1;
        #1;
        total++;
        if (data0.addr_ok !== 1'b0 || m0.req !== 1'b0 || data0.data_ok !== 1'b1 || data0.rdata !== e.rdata) begin
            bad++;
            $display("FAIL full_pop_no_accept: daok=%b m_req=%b ddok=%b rdata=%h, required 0 0 1 %h",
                     data0.addr_ok, m0.req, data0.data_ok, data0.rdata, e.rdata);
        end
        @(negedge aclk);
        m0.data_ok = 0;
        #1;
        total++;
        if (data0.addr_ok !== 1'b1) begin
            bad++;
            $display("FAIL full_accept_after_pop: daok=%b, required 1", data0.addr_ok);
        end
        exp_q.push_back('{1'b1, 32'hD000_0004});
        drain0("full");
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic want_data;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            inst1.req = 1; data1.req = 1; m1.addr_ok = 1;
            want_data = (i % 2 == 0);
            #1;
            total++;
            if (data1.addr_ok !== want_data || inst1.addr_ok !== !want_data) begin
                bad++;
                $display("FAIL rr_grant_%0d: daok=%b iaok=%b, required %b %b",
                         i, data1.addr_ok, inst1.addr_ok, want_data, !want_data);
            end
            exp1_q.push_back('{want_data, want_data ? 32'h1111_1111 : 32'h2222_2222});
        end
        while (exp1_q.size() != 0) begin
            e = exp1_q.pop_front();
            @(negedge aclk);
            inst1.req = 0; data1.req = 0; m1.addr_ok = 0;
            m1.rdata = e.rdata; m1.data_ok = 1;
            #1;
            total++;
            if (data1.data_ok !== e.is_data || inst1.data_ok !== !e.is_data ||
                (e.is_data ? data1.rdata : inst1.rdata) !== e.rdata) begin
                bad++;
                $display("FAIL rr_return: ddok=%b idok=%b rdata=%h, required ddok=%b idok=%b rdata=%h",
                         data1.data_ok, inst1.data_ok, e.is_data ? data1.rdata : inst1.rdata,
                         e.is_data, !e.is_data, e.rdata);
            end
        end
        @(negedge aclk);
        m1.data_ok = 0;
    endtask

    task automatic test_unexpected();
        @(negedge aclk);
        m0.rdata = 32'hDEAD_BEEF; m0.data_ok = 1;
        #1;
        total++;
        if (data0.data_ok !== 1'b0 || inst0.data_ok !== 1'b0 || err0 !== 1'b0) begin
            bad++;
            $display("FAIL unexp_no_pulse: ddok=%b idok=%b err=%b, required 0 0 0", data0.data_ok, inst0.data_ok, err0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            m0.data_ok = 0;
            data0.req = (c == 1); m0.addr_ok = 1;
            #1;
            total++;
            if (err0 !== 1'b1) begin
                bad++;
                $display("FAIL unexp_sticky_%0d: err=%b, required 1", c, err0);
            end
        end
        @(negedge aclk);
        data0.req = 0; m0.addr_ok = 0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            data0.req = 1; m0.addr_ok = 1;
        end
        @(negedge aclk);
        aresetn = 0;
        #1;
        total++;
        if (m0.req !== 1'b0 || data0.addr_ok !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_forced: m_req=%b daok=%b, required 0 0", m0.req, data0.addr_ok);
        end
        @(negedge aclk);
        aresetn = 1; data0.req = 0; m0.addr_ok = 0;
        #1;
        total++;
        if (err0 !== 1'b0 || m0.req !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_cleared: err=%b m_req=%b, required 0 0", err0, m0.req);
        end
        @(negedge aclk);
        m0.rdata = 32'h0BAD_0BAD; m0.data_ok = 1;
        #1;
        total++;
        if (data0.data_ok !== 1'b0 || inst0.data_ok !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_dropped: ddok=%b idok=%b, required 0 0", data0.data_ok, inst0.data_ok);
        end
        @(negedge aclk);
        m0.data_ok = 0;
        #1;
        total++;
        if (err0 !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_stray_err: err=%b, required 1", err0);
        end
        @(negedge aclk);
        aresetn = 0;
        @(negedge aclk);
        aresetn = 1;
        inst0.req = 1; data0.req = 1; m0.addr_ok = 1;
        inst1.req = 1; data1.req = 1; m1.addr_ok = 1;
        #1;
        total++;
        if (data0.addr_ok !== 1'b1 || inst0.addr_ok !== 1'b0 || data1.addr_ok !== 1'b1 ||
            inst1.addr_ok !== 1'b0 || err0 !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_tie: d0=%b i0=%b d1=%b i1=%b err=%b, required 1 0 1 0 0",
                     data0.addr_ok, inst0.addr_ok, data1.addr_ok, inst1.addr_ok, err0);
        end
        @(negedge aclk);
        idle_all();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        aresetn = 0;
        idle_all();
        test_reset();
        test_priority();
        test_lock();
        test_full();
        test_round_robin();
        test_unexpected();
        test_reset_mid();
        repeat (2) @(negedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
